lstm_out_serializer: RTL

LSTM_OUT_SERIALIZER -- requirements
Module: lstm_out_serializer

---
 rtl/lstm_out_serializer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lstm_out_serializer.sv
// Serializes LSTM hidden vectors into a stream of N-bit elements, lowest index first.
// A second buffer holds the following vector so consecutive vectors stream without bubbles.
module lstm_out_serializer #(
  parameter int N           = 8,
  parameter int HIDDEN_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   h_valid,
  input  logic [HIDDEN_SIZE-1:0] h_t,
  output logic                   h_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [((HIDDEN_SIZE/N) > 1 ? $clog2(HIDDEN_SIZE/N) : 1)-1:0] out_index,
  output logic                   out_last,
  output logic                   overrun,
  output logic [7:0]             drop_count
);

  localparam int NUM_ELEMS = HIDDEN_SIZE / N;
  localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  generate
    if (N <= 0 || HIDDEN_SIZE <= 0 || (HIDDEN_SIZE % N) != 0) begin : g_bad_size
      $error("lstm_out_serializer: HIDDEN_SIZE must be a nonzero multiple of N");
    end
  endgenerate

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                   state, state_nxt;
  logic [HIDDEN_SIZE-1:0]   active_buf, active_nxt;
  logic [HIDDEN_SIZE-1:0]   pending_buf, pending_nxt;
  logic                     pending_full, pending_full_nxt;
  logic [IDX_W-1:0]         index, index_nxt;
  logic                     overrun_nxt;
  logic [7:0]               drop_nxt;

  logic accept;
  logic transfer;
  logic dropped;
  logic at_last;

  assign h_ready  = !pending_full;
  assign accept   = h_valid & h_ready;
  assign dropped  = h_valid & !h_ready;
  assign at_last  = (index == IDX_W'(NUM_ELEMS - 1));
  assign transfer = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      active_buf   <= '0;
      pending_buf  <= '0;
      pending_full <= 1'b0;
      index        <= '0;
      overrun      <= 1'b0;
      drop_count   <= 8'd0;
    end else begin
      state        <= state_nxt;
      active_buf   <= active_nxt;
      pending_buf  <= pending_nxt;
      pending_full <= pending_full_nxt;
      index        <= index_nxt;
      overrun      <= overrun_nxt;
      drop_count   <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    active_nxt       = active_buf;
    pending_nxt      = pending_buf;
    pending_full_nxt = pending_full;
    index_nxt        = index;

    case (state)
      IDLE: begin
        if (accept) begin
          active_nxt = h_t;
          index_nxt  = '0;
          state_nxt  = STREAM;
        end
      end
      STREAM: begin
        if (transfer && !at_last) begin
          index_nxt = index + IDX_W'(1);
        end else if (transfer && at_last) begin
          index_nxt = '0;
          if (pending_full) begin
            active_nxt       = pending_buf;
            pending_full_nxt = 1'b0;
          end else if (accept) begin
            active_nxt = h_t;
          end else begin
            state_nxt = IDLE;
          end
        end
        // Accept while the last element leaves goes straight to active instead.
        if (accept && !(transfer && at_last)) begin
          pending_nxt      = h_t;
          pending_full_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase
  end

  always_comb begin
    overrun_nxt = dropped;
    drop_nxt    = drop_count;
    if (dropped && drop_count != 8'hFF) begin
      drop_nxt = drop_count + 8'd1;
    end
  end

  always_comb begin
    out_valid = (state == STREAM);
    out_last  = (state == STREAM) && at_last;
    out_index = index;
    out_data  = '0;
    if (state == STREAM) begin
      for (int k = 0; k < NUM_ELEMS; k++) begin
        if (index == IDX_W'(k)) out_data = active_buf[k*N +: N];
      end
    end
  end

endmodule
